// File: rtl/fpu_conv_pkg.sv
// Shared constants and types for the binary16 -> binary64 lane converter.
// Build option: define FPUCONVH2D_DENORM_EN to normalize subnormal inputs.
package fpu_conv_pkg;

    localparam int unsigned f16W         = 16;
    localparam int unsigned wordW        = 64;
    localparam int unsigned laneCnt      = 4;
    localparam int unsigned laneIdxW     = 2;
    localparam int unsigned fracPadW     = 42;

    localparam int unsigned h2dBiasDelta = 1008;
    localparam int unsigned subnormBase  = 999;
    localparam int unsigned f16ExpMax    = 31;
    localparam int unsigned f64ExpMax    = 2047;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } convState_t;

    typedef struct packed {
        logic       sign;
        logic [4:0] exp;
        logic [9:0] frac;
    } half_t;

    typedef struct packed {
        logic        sign;
        logic [10:0] exp;
        logic [51:0] frac;
    } double_t;

endpackage

// File: rtl/fpu_conv_h2d_seq_if.sv
// Word-in / lane-out handshake bundle for the sequential half-to-double converter.
interface fpu_conv_h2d_seq_if;
    import fpu_conv_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [wordW-1:0]    in_data;
    logic [laneCnt-1:0]  in_mask;
    logic                out_valid;
    logic                out_ready;
    logic [wordW-1:0]    out_data;
    logic [laneIdxW-1:0] out_lane;
    logic                out_last;

    // Producer of words and consumer of results.
    modport master (
        output in_valid, in_data, in_mask, out_ready,
        input  in_ready, out_valid, out_data, out_lane, out_last
    );

    // The converter itself.
    modport slave (
        input  in_valid, in_data, in_mask, out_ready,
        output in_ready, out_valid, out_data, out_lane, out_last
    );

endinterface

// File: rtl/fpu_conv_h2d_lane.sv
// Single-lane binary16 -> binary64 converter, purely combinational and exact.
// Build option: FPUCONVH2D_DENORM_EN normalizes subnormals, otherwise they flush to signed zero.
module fpu_conv_h2d_lane
    import fpu_conv_pkg::*;
(
    input  half_t   halfVal,
    output double_t dbl_c
);

`ifdef FPUCONVH2D_DENORM_EN
    logic [3:0] leadPos;
    logic [9:0] normFrac;

    // Leading-one position of the subnormal fraction and the fraction shifted past it.
    always_comb begin
        leadPos = '0;
        for (int i = 0; i < 10; i++) begin
            if (halfVal.frac[i]) leadPos = 4'(i);
        end
        normFrac = halfVal.frac << (4'd10 - leadPos);
    end
`endif

    always_comb begin
        dbl_c      = '0;
        dbl_c.sign = halfVal.sign;
        if (halfVal.exp == 5'(f16ExpMax)) begin
            dbl_c.exp  = 11'(f64ExpMax);
            dbl_c.frac = {halfVal.frac, fracPadW'(0)};
        end else if (halfVal.exp != '0) begin
            dbl_c.exp  = 11'(halfVal.exp) + 11'(h2dBiasDelta);
            dbl_c.frac = {halfVal.frac, fracPadW'(0)};
        end
`ifdef FPUCONVH2D_DENORM_EN
        else if (halfVal.frac != '0) begin
            dbl_c.exp  = 11'(leadPos) + 11'(subnormBase);
            dbl_c.frac = {normFrac, fracPadW'(0)};
        end
`endif
    end

endmodule

// File: rtl/fpu_conv_h2d_seq.sv
// Accepts a word of packed binary16 lanes and emits each masked lane as binary64, lowest index first.
// Build option: FPUCONVH2D_DENORM_EN (forwarded to the lane converter).
module fpu_conv_h2d_seq
    import fpu_conv_pkg::*;
#(
    parameter int unsigned LANES = 4
) (
    input logic               clock,
    input logic               reset,
    fpu_conv_h2d_seq_if.slave bus
);

    convState_t          state, stateNext;
    logic [wordW-1:0]    wordData, wordDataNext;
    logic [LANES-1:0]    remMask, remMaskNext;
    logic                outValid, outValidNext;
    logic                outLast, outLastNext;
    logic [laneIdxW-1:0] outLane, outLaneNext;
    double_t             outData, outDataNext;

    logic                inReady_c;
    logic                loadNew;
    logic                advance;
    logic [LANES-1:0]    srcMask;
    logic [LANES-1:0]    restMask;
    logic [wordW-1:0]    srcData;
    logic [laneIdxW-1:0] selLane;
    half_t               laneHalf;
    double_t             laneDbl;

    // A new word may enter while idle, or in the very cycle the final lane leaves.
    assign inReady_c = (state == IDLE) || (outLast && bus.out_ready);

    // Pick the lowest pending lane, either from the word arriving now or the held one.
    always_comb begin
        loadNew = bus.in_valid && inReady_c && (bus.in_mask != '0);
        advance = (state == EMIT) && bus.out_ready && !outLast;
        srcMask = loadNew ? bus.in_mask : remMask;
        srcData = loadNew ? bus.in_data : wordData;
        selLane = '0;
        for (int k = LANES - 1; k >= 0; k--) begin
            if (srcMask[k]) selLane = laneIdxW'(k);
        end
        restMask = srcMask & ~(LANES'(1) << selLane);
        laneHalf = srcData[{selLane, 4'b0000} +: f16W];
    end

    fpu_conv_h2d_lane uLane (
        .halfVal (laneHalf),
        .dbl_c   (laneDbl)
    );

    always_comb begin
        stateNext    = state;
        wordDataNext = wordData;
        remMaskNext  = remMask;
        outValidNext = outValid;
        outDataNext  = outData;
        outLaneNext  = outLane;
        outLastNext  = outLast;
        if (loadNew || advance) begin
            stateNext    = EMIT;
            outValidNext = 1'b1;
            outDataNext  = laneDbl;
            outLaneNext  = selLane;
            outLastNext  = (restMask == '0);
            remMaskNext  = restMask;
            if (loadNew) wordDataNext = bus.in_data;
        end else if ((state == EMIT) && bus.out_ready) begin
            // Final lane consumed with no follow-on word (a zero-mask word is dropped here).
            stateNext    = IDLE;
            outValidNext = 1'b0;
            outLastNext  = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            wordData <= '0;
            remMask  <= '0;
            outValid <= 1'b0;
            outData  <= '0;
            outLane  <= '0;
            outLast  <= 1'b0;
        end else begin
            state    <= stateNext;
            wordData <= wordDataNext;
            remMask  <= remMaskNext;
            outValid <= outValidNext;
            outData  <= outDataNext;
            outLane  <= outLaneNext;
            outLast  <= outLastNext;
        end
    end

    assign bus.in_ready  = inReady_c;
    assign bus.out_valid = outValid;
    assign bus.out_data  = outData;
    assign bus.out_lane  = outLane;
    assign bus.out_last  = outLast;

endmodule

// File: tb/tb_fpu_conv_h2d_seq.sv
// Self-checking bench for fpu_conv_h2d_seq: directed vectors plus random words against a real-arithmetic model.
// Honours FPUCONVH2D_DENORM_EN the same way the design does.
module tb_fpu_conv_h2d_seq;
    import fpu_conv_pkg::*;

    typedef struct packed {
        logic [63:0] d;
        logic [1:0]  lane;
        logic        last;
    } beat_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    fpu_conv_h2d_seq_if bus ();

    fpu_conv_h2d_seq #(.LANES(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    beat_t       expQ[$];
    logic [63:0] logData[$];
    logic [1:0]  logLane[$];
    logic        logLast[$];
    int          logCyc[$];

    logic        drvValid   = 1'b0;
    logic [63:0] drvData    = '0;
    logic [3:0]  drvMask    = '0;
    int          readyMode  = 0;
    logic        readyPhase = 1'b1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    function automatic real pow2(input int n);
        real r;
        r = 1.0;
        if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
        else        for (int i = 0; i < -n; i++) r = r / 2.0;
        return r;
    endfunction

    // Decode the half value numerically and let the simulator encode it as a double.
    function automatic logic [63:0] h2dRef(input logic [15:0] h);
        logic        s;
        int          e;
        int          f;
        real         mag;
        logic [63:0] bits;
        s   = h[15];
        e   = int'(h[14:10]);
        f   = int'(h[9:0]);
        mag = 0.0;
        if (e == 31) return {s, 11'h7FF, h[9:0], 42'd0};
        if (e == 0 && f == 0) return {s, 63'd0};
        if (e == 0) begin
`ifdef FPUCONVH2D_DENORM_EN
            mag = real'(f) * pow2(-24);
`else
            return {s, 63'd0};
`endif
        end else begin
            mag = real'(1024 + f) * pow2(e - 25);
        end
        bits = $realtobits(mag);
        return {s, bits[62:0]};
    endfunction

    function automatic logic [15:0] randHalf();
        logic       s;
        logic [9:0] f;
        s = 1'($urandom_range(0, 1));
        f = 10'($urandom_range(1, 1023));
        case ($urandom_range(0, 5))
            0:       return {s, 5'($urandom_range(1, 30)), 10'($urandom)};
            1:       return {s, 15'd0};
            2:       return {s, 5'd0, f};
            3:       return {s, 5'd31, 10'd0};
            4:       return {s, 5'd31, f};
            default: return 16'($urandom);
        endcase
    endfunction

    // One clock: drive at the falling edge, observe 1 time unit later, update the model.
    task automatic step();
        beat_t b;
        @(negedge clock);
        cyc++;
        bus.in_valid = drvValid;
        bus.in_data  = drvData;
        bus.in_mask  = drvMask;
        case (readyMode)
            0: bus.out_ready = 1'b1;
            1: begin
                bus.out_ready = readyPhase;
                readyPhase    = ~readyPhase;
            end
            default: bus.out_ready = 1'($urandom_range(0, 1));
        endcase
        #1;
        chk("out_valid", 64'(bus.out_valid), 64'(expQ.size() != 0));
        chk("in_ready", 64'(bus.in_ready),
            64'((expQ.size() == 0) || (expQ.size() == 1 && bus.out_ready)));
        if (bus.out_valid && expQ.size() != 0) begin
            chk("out_data", bus.out_data, expQ[0].d);
            chk("out_lane", 64'(bus.out_lane), 64'(expQ[0].lane));
            chk("out_last", 64'(bus.out_last), 64'(expQ[0].last));
            if (bus.out_ready) begin
                logData.push_back(bus.out_data);
                logLane.push_back(bus.out_lane);
                logLast.push_back(bus.out_last);
                logCyc.push_back(cyc);
                void'(expQ.pop_front());
            end
        end
        if (bus.in_valid && bus.in_ready) begin
            for (int k = 0; k < 4; k++) begin
                if (bus.in_mask[k]) begin
                    b.d    = h2dRef(bus.in_data[16*k +: 16]);
                    b.lane = 2'(k);
                    b.last = ((bus.in_mask >> (k + 1)) == 4'd0);
                    expQ.push_back(b);
                end
            end
            drvValid = 1'b0;
        end
    endtask

    task automatic resetStep();
        @(negedge clock);
        cyc++;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drvValid      = 1'b0;
        expQ.delete();
        @(negedge clock);
        cyc++;
        reset = 1'b0;
        #1;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_data", bus.out_data, 64'd0);
        chk("rst_out_lane", 64'(bus.out_lane), 64'd0);
        chk("rst_out_last", 64'(bus.out_last), 64'd0);
    endtask

    task automatic sendWord(input logic [63:0] d, input logic [3:0] m);
        drvValid = 1'b1;
        drvData  = d;
        drvMask  = m;
        for (int n = 0; n < 64 && drvValid; n++) step();
        if (drvValid) begin
            chk("accept_timeout", 64'(drvValid), 64'd0);
            drvValid = 1'b0;
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 64 && expQ.size() != 0; n++) step();
        chk("drain_timeout", 64'(expQ.size()), 64'd0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          mark;
        logic [63:0] subExp;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_mask   = '0;
        bus.out_ready = 1'b1;

        resetStep();
        step();

        // Four-lane word with one, infinity, quiet NaN and minus two.
        mark = logData.size();
        sendWord(64'hC000_7E00_7C00_3C00, 4'hF);
        drain();
        chk("v28_beats", 64'(logData.size() - mark), 64'd4);
        if (logData.size() >= mark + 4) begin
            chk("v28_lane0", logData[mark],     64'h3FF0000000000000);
            chk("v28_lane1", logData[mark + 1], 64'h7FF0000000000000);
            chk("v28_lane2", logData[mark + 2], 64'h7FF8000000000000);
            chk("v28_lane3", logData[mark + 3], 64'hC000000000000000);
            chk("v28_idx3",  64'(logLane[mark + 3]), 64'd3);
            chk("v28_last3", 64'(logLast[mark + 3]), 64'd1);
            chk("v28_last0", 64'(logLast[mark]), 64'd0);
        end

        // Single-lane word.
        mark = logData.size();
        sendWord(64'h0000_0000_0000_3555, 4'h1);
        drain();
        chk("v29_beats", 64'(logData.size() - mark), 64'd1);
        if (logData.size() >= mark + 1) begin
            chk("v29_data", logData[mark], 64'h3FD5540000000000);
            chk("v29_lane", 64'(logLane[mark]), 64'd0);
            chk("v29_last", 64'(logLast[mark]), 64'd1);
        end

        // Smallest subnormal and negative zero.
`ifdef FPUCONVH2D_DENORM_EN
        subExp = 64'h3E70000000000000;
`else
        subExp = 64'h0000000000000000;
`endif
        mark = logData.size();
        sendWord(64'h0000_0000_8000_0001, 4'h3);
        drain();
        chk("v30_beats", 64'(logData.size() - mark), 64'd2);
        if (logData.size() >= mark + 2) begin
            chk("v30_subnorm", logData[mark], subExp);
            chk("v30_negzero", logData[mark + 1], 64'h8000000000000000);
        end

        // Sparse mask under a toggling consumer.
        mark       = logData.size();
        readyMode  = 1;
        readyPhase = 1'b1;
        sendWord(64'h4400_3800_BC00_0400, 4'b1010);
        drain();
        readyMode = 0;
        chk("v31_beats", 64'(logData.size() - mark), 64'd2);
        if (logData.size() >= mark + 2) begin
            chk("v31_first_lane", 64'(logLane[mark]), 64'd1);
            chk("v31_second_lane", 64'(logLane[mark + 1]), 64'd3);
        end

        // Back-to-back words stream without a bubble.
        mark = logData.size();
        sendWord(64'h3C00_4000_4200_4400, 4'hF);
        sendWord(64'h0000_0000_0000_4500, 4'h1);
        drain();
        chk("b2b_beats", 64'(logData.size() - mark), 64'd5);
        if (logData.size() >= mark + 5)
            chk("b2b_span", 64'(logCyc[mark + 4] - logCyc[mark]), 64'd4);

        // A zero-mask word in between contributes nothing.
        mark = logData.size();
        sendWord(64'h3C00_4000_4200_4400, 4'hF);
        sendWord(64'h7C00_7C00_7C00_7C00, 4'h0);
        sendWord(64'h0000_0000_0000_4500, 4'h1);
        drain();
        chk("zm_beats", 64'(logData.size() - mark), 64'd5);
        if (logData.size() >= mark + 5) begin
            chk("zm_span4", 64'(logCyc[mark + 3] - logCyc[mark]), 64'd3);
            chk("zm_fifth", logData[mark + 4], 64'h4014000000000000);
        end

        // Reset after the second beat of a four-lane word.
        mark = logData.size();
        sendWord(64'h4800_4600_4400_4200, 4'hF);
        for (int n = 0; n < 16 && logData.size() < mark + 2; n++) step();
        resetStep();
        step();
        step();
        chk("rst_mid_beats", 64'(logData.size() - mark), 64'd2);
        mark = logData.size();
        sendWord(64'h4800_4600_4400_4200, 4'b0110);
        drain();
        chk("rst_restart_beats", 64'(logData.size() - mark), 64'd2);
        if (logData.size() >= mark + 1)
            chk("rst_restart_lane", 64'(logLane[mark]), 64'd1);

        // Random words, masks and consumer stalls.
        for (int w = 0; w < 80; w++) begin
            logic [63:0] d;
            d         = {randHalf(), randHalf(), randHalf(), randHalf()};
            readyMode = ($urandom_range(0, 2) == 0) ? 0 : 2;
            sendWord(d, 4'($urandom_range(0, 15)));
        end
        readyMode = 0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
